// File: rtl/aes_192_ctr_stream.sv
// AES-192 counter-mode stream engine with one block in flight: out = in ^ AES192(key, ctr).
// Define AES_CTR_STREAM_WRAP_ERR_EN to flag a counter wrap on err and end the message.

module aes_192 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state,
  input  logic [191:0] key,
  output logic [127:0] out,
  output logic         out_valid
);
  logic [127:0] s_q, round_out;
  logic [191:0] win_q, win_next, key_win;
  logic [3:0]   rnd_q;
  logic         run_q, start_q, out_valid_q;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse as a^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Window holds words w[4r .. 4r+5]; returns w[4r+4 .. 4r+9].
  function automatic logic [191:0] advance(input logic [191:0] win, input logic [3:0] r);
    logic [31:0] w [10];
    logic [31:0] t;
    logic [7:0]  rc;
    int          idx;
    for (int k = 0; k < 6; k++) w[k] = win[191 - 32*k -: 32];
    for (int k = 6; k < 10; k++) begin
      idx = 4 * int'(r) + k;
      t   = w[k-1];
      if (idx % 6 == 0) begin
        rc = 8'h01 << (idx / 6 - 1);
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end
      w[k] = w[k-6] ^ t;
    end
    return {w[4], w[5], w[6], w[7], w[8], w[9]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int j = 0; j < 16; j++) b[j] = sbox(s[127 - 8*j -: 8]);
    for (int j = 0; j < 16; j++) t[j] = b[(j % 4) + 4 * (((j / 4) + (j % 4)) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int j = 0; j < 16; j++) r[127 - 8*j -: 8] = t[j];
    return r ^ rk;
  endfunction

  always_comb begin
    round_out = aes_round(s_q, win_q[191:64], rnd_q == 4'd12);
    win_next  = advance(win_q, rnd_q);
    key_win   = advance(key, 4'd0);
  end

  // out_valid stays up until start drops, so every run needs a fresh 0->1 start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q         <= '0;
      win_q       <= '0;
      rnd_q       <= '0;
      run_q       <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      start_q <= start;
      if (!start) out_valid_q <= 1'b0;
      if (start && !start_q && !run_q) begin
        s_q         <= state ^ key[191:64];
        win_q       <= key_win;
        rnd_q       <= 4'd1;
        run_q       <= 1'b1;
        out_valid_q <= 1'b0;
      end else if (run_q) begin
        s_q   <= round_out;
        win_q <= win_next;
        rnd_q <= rnd_q + 4'd1;
        if (rnd_q == 4'd12) begin
          run_q       <= 1'b0;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign out       = s_q;
  assign out_valid = out_valid_q;
endmodule

module aes_192_ctr_stream #(
  parameter int unsigned CTR_W     = 32,
  parameter int unsigned BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 msg_start,
  input  logic [191:0]         key,
  input  logic [127:0]         iv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blk_cnt,
  output logic                 err
);
  typedef enum logic [2:0] {StIdle, StWaitIn, StArm, StRun, StOut} state_e;

  state_e               state_q, state_d;
  logic [191:0]         key_q;
  logic [127:0]         ctr_q, ctr_d, data_q, out_data_q, core_out;
  logic                 last_q, core_start, core_valid;
  logic [BLK_CNT_W-1:0] blk_cnt_q;
  logic                 start_fire, in_fire, out_fire;

  aes_192 u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (core_start),
    .state     (ctr_q),
    .key       (key_q),
    .out       (core_out),
    .out_valid (core_valid)
  );

  // A new message start in WAIT_IN takes priority over a same-cycle input block.
  assign start_fire = msg_start && (state_q == StIdle || state_q == StWaitIn);
  assign in_fire    = in_valid && state_q == StWaitIn && !msg_start;
  assign out_fire   = out_ready && state_q == StOut;

`ifdef AES_CTR_STREAM_WRAP_ERR_EN
  logic err_q, wrap;
  assign wrap = &ctr_q[CTR_W-1:0];
  assign err  = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d              = state_q;
    core_start           = 1'b0;
    ctr_d                = ctr_q;
    ctr_d[CTR_W-1:0]     = ctr_q[CTR_W-1:0] + CTR_W'(1);
    in_ready             = state_q == StWaitIn;
    out_valid            = state_q == StOut;
    busy                 = state_q != StIdle;
    unique case (state_q)
      StIdle:   if (msg_start) state_d = StWaitIn;
      StWaitIn: if (in_fire) state_d = StArm;
      StArm:    if (!core_valid) state_d = StRun;
      StRun: begin
        core_start = 1'b1;
        if (core_valid) state_d = StOut;
      end
      StOut: begin
        if (out_ready) begin
`ifdef AES_CTR_STREAM_WRAP_ERR_EN
          state_d = (last_q || wrap) ? StIdle : StWaitIn;
`else
          state_d = last_q ? StIdle : StWaitIn;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      key_q      <= '0;
      ctr_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      out_data_q <= '0;
      blk_cnt_q  <= '0;
`ifdef AES_CTR_STREAM_WRAP_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (start_fire) begin
        key_q     <= key;
        ctr_q     <= iv;
        blk_cnt_q <= '0;
`ifdef AES_CTR_STREAM_WRAP_ERR_EN
        err_q     <= 1'b0;
`endif
      end
      if (in_fire) begin
        data_q <= in_data;
        last_q <= in_last;
      end
      if (state_q == StRun && core_valid) out_data_q <= data_q ^ core_out;
      if (out_fire) begin
        ctr_q     <= ctr_d;
        blk_cnt_q <= blk_cnt_q + BLK_CNT_W'(1);
`ifdef AES_CTR_STREAM_WRAP_ERR_EN
        if (wrap) err_q <= 1'b1;
`endif
      end
    end
  end

  assign out_data = out_data_q;
  assign out_last = last_q;
  assign blk_cnt  = blk_cnt_q;
endmodule
